// File: rtl/channel_accum_4to1_x16.sv
// Two-stage channel reduction: sums four 11-bit product channels per tile element
// and saturates each of the 16 element sums back to 11-bit signed.
module channel_accum_4to1_x16 (
    input  logic         clk,
    input  logic         rst,
    input  logic [703:0] UpV,
    output logic [175:0] UpV_Accumu1_16
);

    function automatic logic [10:0] sat11(input logic signed [12:0] t);
        if (t > 13'sd1023) begin
            return 11'h3FF;
        end else if (t < -13'sd1024) begin
            return 11'h400;
        end else begin
            return t[10:0];
        end
    endfunction

    for (genvar e = 0; e < 16; e++) begin : g_lane
        logic signed [10:0] p0, p1, p2, p3;
        logic signed [11:0] s01, s23;
        logic signed [12:0] t;

        assign p0 = UpV[0*176 + e*11 +: 11];
        assign p1 = UpV[1*176 + e*11 +: 11];
        assign p2 = UpV[2*176 + e*11 +: 11];
        assign p3 = UpV[3*176 + e*11 +: 11];

        // 12 + 12 -> 13 bits holds the full four-way sum, so saturation only happens once
        always_comb begin
            t = {s01[11], s01} + {s23[11], s23};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s01                      <= '0;
                s23                      <= '0;
                UpV_Accumu1_16[e*11 +: 11] <= '0;
            end else begin
                s01                      <= {p0[10], p0} + {p1[10], p1};
                s23                      <= {p2[10], p2} + {p3[10], p3};
                UpV_Accumu1_16[e*11 +: 11] <= sat11(t);
            end
        end
    end

endmodule

// File: tb/tb_channel_accum_4to1_x16.sv
// Self-checking bench for channel_accum_4to1_x16: directed vector table, reset
// corner cases and a randomized stream against an integer reference model.
module tb_channel_accum_4to1_x16;

    logic         clk = 1'b0;
    logic         rst;
    logic [703:0] UpV;
    logic [175:0] UpV_Accumu1_16;

    int n_checks = 0;
    int n_fail   = 0;

    channel_accum_4to1_x16 dut (
        .clk            (clk),
        .rst            (rst),
        .UpV            (UpV),
        .UpV_Accumu1_16 (UpV_Accumu1_16)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [703:0] upv;
        logic [175:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [703:0] put_in(logic [703:0] u, int c, int e, int v);
        u[c*176 + e*11 +: 11] = 11'(v);
        return u;
    endfunction

    function automatic logic [175:0] put_out(logic [175:0] o, int e, int v);
        o[e*11 +: 11] = 11'(v);
        return o;
    endfunction

    // Reference: plain integer sum of the four channels, clamped to [-1024, 1023]
    function automatic logic [175:0] ref_out(logic [703:0] u);
        logic [175:0]       r;
        logic signed [10:0] x;
        int                 s;
        r = '0;
        for (int e = 0; e < 16; e++) begin
            s = 0;
            for (int c = 0; c < 4; c++) begin
                x = u[c*176 + e*11 +: 11];
                s += int'(x);
            end
            if (s > 1023) s = 1023;
            if (s < -1024) s = -1024;
            r[e*11 +: 11] = 11'(s);
        end
        return r;
    endfunction

    function automatic logic [703:0] rand_upv();
        logic [703:0] u;
        for (int k = 0; k < 22; k++) u[k*32 +: 32] = $urandom;
        return u;
    endfunction

    task automatic check(string name, logic [175:0] act, logic [175:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(string name, int a0, int a1, int a2, int a3, int lane, int res);
        vec_t v;
        v.name = name;
        v.upv  = '0;
        v.exp  = '0;
        for (int e = 0; e < 16; e++) begin
            if (lane < 0 || lane == e) begin
                v.upv = put_in(v.upv, 0, e, a0);
                v.upv = put_in(v.upv, 1, e, a1);
                v.upv = put_in(v.upv, 2, e, a2);
                v.upv = put_in(v.upv, 3, e, a3);
                v.exp = put_out(v.exp, e, res);
            end
        end
        tbl.push_back(v);
    endtask

    initial begin
        vec_t         v;
        logic [175:0] prev;
        logic [175:0] hist[$];
        logic [703:0] r;

        // Directed table with hand-derived expectations
        v.name = "basic_sum";
        v.upv  = '0;
        v.exp  = '0;
        for (int e = 0; e < 16; e++) begin
            for (int c = 0; c < 4; c++) v.upv = put_in(v.upv, c, e, e + 1);
            v.exp = put_out(v.exp, e, 4 * (e + 1));
        end
        tbl.push_back(v);
        add_vec("signed_mix_e0",  100,  -30,  -50,    5,  0,    25);
        add_vec("all_minus1",      -1,   -1,   -1,   -1, -1,    -4);
        add_vec("sat_pos_max",   1023, 1023, 1023, 1023, -1,  1023);
        add_vec("sat_neg_min",  -1024,-1024,-1024,-1024, -1, -1024);
        add_vec("sat_pos_mixed",  600,  600, -100,    0, -1,  1023);
        add_vec("sat_neg_mixed", -600, -600,  100,    0, -1, -1024);
        add_vec("lane7_only",       1,    2,    3,    4,  7,    10);

        // Reset asserted with random input: output is zero before any clock edge
        rst = 1'b1;
        UpV = rand_upv();
        #3;
        check("reset_async_start", UpV_Accumu1_16, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", UpV_Accumu1_16, '0);
        UpV = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_zero", UpV_Accumu1_16, '0);

        // Each vector: unchanged after 1 edge, new result after exactly 2
        prev = '0;
        foreach (tbl[i]) begin
            UpV = tbl[i].upv;
            @(posedge clk);
            #1;
            check({tbl[i].name, "_lat1"}, UpV_Accumu1_16, prev);
            @(posedge clk);
            #1;
            check(tbl[i].name, UpV_Accumu1_16, tbl[i].exp);
            prev = tbl[i].exp;
        end

        // Mid-stream reset: clears at once, refills 2 edges after release
        UpV = rand_upv();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async_mid", UpV_Accumu1_16, '0);
        @(posedge clk);
        #1;
        r   = rand_upv();
        UpV = r;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_edge1", UpV_Accumu1_16, '0);
        @(posedge clk);
        #1;
        check("release_edge2", UpV_Accumu1_16, ref_out(r));

        // Randomized stream, a new vector every cycle
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            if (hist.size() == 2) check("stream", UpV_Accumu1_16, hist.pop_front());
            r   = rand_upv();
            UpV = r;
            hist.push_back(ref_out(r));
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            check("stream_tail", UpV_Accumu1_16, hist.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_accum_4to1_x16.md
# channel_accum_4to1_x16

Pipelined channel reduction stage of the Winograd F(2,3) convolution datapath. It takes the 64 signed 11-bit element-wise products from one DSP16_16 array and adds the four partial channels of each of the 16 transform-domain tile elements. The result is 16 signed 11-bit partial sums for the downstream multi-pass Channel_Accumulator. It sits between the DSP multiply array and the channel accumulator; four instances run in parallel, one per output-channel group.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all pipeline registers.
- UpV  input  704  products; 4 channel slices × 16 elements × 11-bit signed two's complement.
- UpV_Accumu1_16  output  176  16 elements × 11-bit signed channel sums, registered.

## Operation
- Input packing:
  - Channel c (0..3) occupies UpV[c*176 +: 176].
  - Element e (0..15) of channel c is p[c][e] = UpV[c*176 + e*11 +: 11].
- Output packing: element e is UpV_Accumu1_16[e*11 +: 11].
- Stage 1, registered:
  - s01[e] = p[0][e] + p[1][e], sign-extended to 12 bits.
  - s23[e] = p[2][e] + p[3][e], sign-extended to 12 bits.
- Stage 2, registered:
  - t[e] = s01[e] + s23[e], 13-bit signed, exact with no overflow.
  - t[e] is saturated to 11-bit signed range: t > 1023 → 1023 (11'h3FF); t < −1024 → −1024 (11'h400); otherwise t[10:0].
- All 16 lanes are identical and independent; no cross-lane interaction.
- No enable or valid: the pipeline advances every cycle. Framing is done upstream and downstream by the WRA_ctl state delays.
- No rounding, no shifting; fixed-point alignment is inherited from DSP16_16.

## Timing
- Latency: 2 clk cycles. Input sampled at edge N appears on UpV_Accumu1_16 after edge N+1. Throughput: 1 input word per cycle.
- Reset:
  - While rst is high, all stage-1 and stage-2 registers and UpV_Accumu1_16 are 0, immediately and independently of clk.
  - After rst deasserts, the first valid output appears 2 edges after the first sampled input.
- Reset mid-stream: in-flight data is discarded. Outputs read 0 until the pipeline refills 2 cycles after release.
- Boundary arithmetic:
  - The maximum positive sum 4×1023 = 4092 saturates to 1023.
  - The minimum sum 4×(−1024) = −4096 saturates to −1024.
  - Mixed-sign sums that fit in range pass exactly.
- Output is stable between clock edges; no combinational path from UpV to the output.

## Test plan
- Reset:
  - Assert rst asynchronously with random UpV → output is 176'h0 at once, and stays 0 for 2 edges after release.
  - Assert rst mid-stream → output is 0 immediately.
- Basic sum: all channels, element e = e+1 → element e output = 4(e+1); e.g. e=15 gives 64. Appears exactly 2 cycles after input.
- Signed mix, element 0: p = {+100, −30, −50, +5} → +25. Same element with all p = −1 → −4 (11'h7FC).
- Saturation:
  - All p = 1023 → 1023 for every element.
  - All p = −1024 → −1024 (11'h400).
  - p = {600, 600, −100, 0} → 1023.
- Lane isolation: drive element 7 only with {1,2,3,4}, all others 0 → element 7 = 10; every other element = 0.
- Streaming: apply a new random vector every cycle for 1000 cycles → each output equals the saturated reference sum of the input from 2 cycles earlier, with no bubbles.
